// File: rtl/pc_redirect_ctrl_if.sv
// Execute-to-fetch control bundle for pc_redirect_ctrl.
// master = execute/fetch side, slave = the PC controller.
interface pc_redirect_ctrl_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        flush_o;
  logic        stall_o;
  logic        trap_o;
  logic [31:0] bad_addr_o;

  modport master (
    output jump_en_i,
    output jump_addr_i,
    output hold_flag_i,
    input  pc_o,
    input  inst_valid_o,
    input  flush_o,
    input  stall_o,
    input  trap_o,
    input  bad_addr_o
  );

  modport slave (
    input  jump_en_i,
    input  jump_addr_i,
    input  hold_flag_i,
    output pc_o,
    output inst_valid_o,
    output flush_o,
    output stall_o,
    output trap_o,
    output bad_addr_o
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC owner: redirect/stall handling, fetch-valid and IF/ID, ID/EX flush/stall.
// Optional misaligned-jump trap enabled by macro PC_CTRL_MISALIGN_CHK_EN.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] TRAP_ADDR    = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  pc_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    BUBBLE,
    HOLD
  } state_t;

  localparam logic [2:0] FLUSH_M1 =
    (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] target;
  logic        misalign;
  logic        accept;
  logic        valid;
  logic        flush;
  logic        stall;

`ifdef PC_CTRL_MISALIGN_CHK_EN
  logic        trap_q;
  logic [31:0] bad_q;
  logic [31:0] bad_d;

  assign misalign = bus.jump_addr_i[1];
  assign target   = misalign ? TRAP_ADDR
                  : {bus.jump_addr_i[31:1], 1'b0};
`else
  logic unused_cfg;

  assign unused_cfg = ^{TRAP_ADDR, bus.jump_addr_i[1:0]};
  assign misalign   = 1'b0;
  assign target     = {bus.jump_addr_i[31:2], 2'b00};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    accept  = 1'b0;
    valid   = 1'b0;
    flush   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        valid = 1'b1;
        if (bus.jump_en_i) begin
          accept = 1'b1;
        end else if (bus.hold_flag_i) begin
          stall   = 1'b1;
          state_d = HOLD;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      HOLD: begin
        valid = 1'b1;
        if (bus.jump_en_i) begin
          accept = 1'b1;
        end else if (bus.hold_flag_i) begin
          stall = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      BUBBLE: begin
        if (bus.jump_en_i) begin
          accept = 1'b1;
        end else if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    // A redirect overrides everything decided above.
    if (accept) begin
      flush   = 1'b1;
      stall   = 1'b0;
      pc_d    = target;
      cnt_d   = FLUSH_M1;
      state_d = (FLUSH_CYCLES > 0) ? BUBBLE : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_CTRL_MISALIGN_CHK_EN
  always_comb begin
    bad_d = bad_q;
    if (accept && misalign) begin
      bad_d = bus.jump_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
      bad_q  <= 32'd0;
    end else begin
      trap_q <= accept & misalign;
      bad_q  <= bad_d;
    end
  end

  assign bus.trap_o     = trap_q;
  assign bus.bad_addr_o = bad_q;
`else
  logic unused_mis;

  assign unused_mis     = misalign;
  assign bus.trap_o     = 1'b0;
  assign bus.bad_addr_o = 32'd0;
`endif

  assign bus.pc_o         = pc_q;
  assign bus.inst_valid_o = valid;
  assign bus.flush_o      = flush & ~rst;
  assign bus.stall_o      = stall & ~rst;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: default instance plus a
// RESET_ADDR=0x1000 / FLUSH_CYCLES=2 instance driven in lockstep.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold;
  int          n_chk = 0;
  int          n_fail = 0;

  pc_redirect_ctrl_if bus_a ();
  pc_redirect_ctrl_if bus_b ();

  assign bus_a.jump_en_i   = jump_en;
  assign bus_a.jump_addr_i = jump_addr;
  assign bus_a.hold_flag_i = hold;
  assign bus_b.jump_en_i   = jump_en;
  assign bus_b.jump_addr_i = jump_addr;
  assign bus_b.hold_flag_i = hold;

  pc_redirect_ctrl u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pc_redirect_ctrl #(
    .RESET_ADDR   (32'h0000_1000),
    .FLUSH_CYCLES (2)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  logic [34:0] obs_a;
  logic [34:0] obs_b;
  assign obs_a = {bus_a.pc_o, bus_a.inst_valid_o,
                  bus_a.flush_o, bus_a.stall_o};
  assign obs_b = {bus_b.pc_o, bus_b.inst_valid_o,
                  bus_b.flush_o, bus_b.stall_o};

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    jump_en = 1'b0;
    hold = 1'b0;
    jump_addr = 32'h0;
    adv();
    jump_en = 1'b1;
    hold = 1'b1;
    #1;
    n_chk++;
    if ({bus_a.flush_o, bus_a.stall_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ctl got %b want 00",
               {bus_a.flush_o, bus_a.stall_o});
    end
    jump_en = 1'b0;
    hold = 1'b0;
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL rst_a got %h want %h", obs_a, {32'h0, 3'b000});
    end
    n_chk++;
    if (obs_b !== {32'h1000, 3'b000}) begin
      n_fail++;
      $display("FAIL rst_b got %h want %h", obs_b, {32'h1000, 3'b000});
    end
    n_chk++;
    if ({bus_a.trap_o, bus_a.bad_addr_o} !== 33'h0) begin
      n_fail++;
      $display("FAIL rst_trap got %h want 0",
               {bus_a.trap_o, bus_a.bad_addr_o});
    end
    rst = 1'b0;
    jump_en = 1'b1;
    jump_addr = 32'h500;
    #1;
    n_chk++;
    if (obs_a !== {32'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL boot got %h want %h", obs_a, {32'h0, 3'b000});
    end
    adv();
    jump_en = 1'b0;
    #1;
    n_chk++;
    if (obs_a !== {32'h0, 3'b100}) begin
      n_fail++;
      $display("FAIL run0 got %h want %h", obs_a, {32'h0, 3'b100});
    end
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h4, 3'b100}) begin
      n_fail++;
      $display("FAIL run4 got %h want %h", obs_a, {32'h4, 3'b100});
    end
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h8, 3'b100}) begin
      n_fail++;
      $display("FAIL run8 got %h want %h", obs_a, {32'h8, 3'b100});
    end
  endtask

  task automatic test_redirect();
    adv();
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h10, 3'b100}) begin
      n_fail++;
      $display("FAIL pre_jmp got %h want %h", obs_a, {32'h10, 3'b100});
    end
    jump_en = 1'b1;
    jump_addr = 32'h40;
    #1;
    n_chk++;
    if (obs_a !== {32'h10, 3'b110}) begin
      n_fail++;
      $display("FAIL jmp_flush got %h want %h", obs_a, {32'h10, 3'b110});
    end
    adv();
    jump_en = 1'b0;
    #1;
    n_chk++;
    if (obs_a !== {32'h40, 3'b000}) begin
      n_fail++;
      $display("FAIL jmp_bub_a got %h want %h", obs_a, {32'h40, 3'b000});
    end
    n_chk++;
    if (obs_b !== {32'h40, 3'b000}) begin
      n_fail++;
      $display("FAIL jmp_bub_b got %h want %h", obs_b, {32'h40, 3'b000});
    end
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h40, 3'b100}) begin
      n_fail++;
      $display("FAIL jmp_run_a got %h want %h", obs_a, {32'h40, 3'b100});
    end
    n_chk++;
    if (obs_b !== {32'h40, 3'b000}) begin
      n_fail++;
      $display("FAIL jmp_bub2_b got %h want %h", obs_b, {32'h40, 3'b000});
    end
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h44, 3'b100}) begin
      n_fail++;
      $display("FAIL jmp_inc_a got %h want %h", obs_a, {32'h44, 3'b100});
    end
    n_chk++;
    if (obs_b !== {32'h40, 3'b100}) begin
      n_fail++;
      $display("FAIL jmp_run_b got %h want %h", obs_b, {32'h40, 3'b100});
    end
  endtask

  task automatic test_hold();
    jump_en = 1'b1;
    jump_addr = 32'h20;
    adv();
    jump_en = 1'b0;
    adv();
    hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs_a !== {32'h20, 3'b101}) begin
        n_fail++;
        $display("FAIL stall%0d got %h want %h", i, obs_a,
                 {32'h20, 3'b101});
      end
      if (i < 2) begin
        adv();
        #1;
      end
    end
    hold = 1'b0;
    #1;
    n_chk++;
    if (obs_a !== {32'h20, 3'b100}) begin
      n_fail++;
      $display("FAIL release got %h want %h", obs_a, {32'h20, 3'b100});
    end
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h20, 3'b100}) begin
      n_fail++;
      $display("FAIL rel_run got %h want %h", obs_a, {32'h20, 3'b100});
    end
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h24, 3'b100}) begin
      n_fail++;
      $display("FAIL rel_inc got %h want %h", obs_a, {32'h24, 3'b100});
    end
  endtask

  task automatic test_jump_hold();
    jump_en = 1'b1;
    hold = 1'b1;
    jump_addr = 32'h80;
    #1;
    n_chk++;
    if (obs_a !== {32'h24, 3'b110}) begin
      n_fail++;
      $display("FAIL jh_a got %h want %h", obs_a, {32'h24, 3'b110});
    end
    n_chk++;
    if ({bus_b.flush_o, bus_b.stall_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL jh_b got %b want 10",
               {bus_b.flush_o, bus_b.stall_o});
    end
    adv();
    jump_en = 1'b0;
    hold = 1'b0;
    #1;
    n_chk++;
    if (obs_a !== {32'h80, 3'b000}) begin
      n_fail++;
      $display("FAIL jh_pc got %h want %h", obs_a, {32'h80, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    jump_en = 1'b1;
    jump_addr = 32'h200;
    #1;
    n_chk++;
    if (obs_a !== {32'h80, 3'b010}) begin
      n_fail++;
      $display("FAIL b2b_a got %h want %h", obs_a, {32'h80, 3'b010});
    end
    n_chk++;
    if (obs_b !== {32'h80, 3'b010}) begin
      n_fail++;
      $display("FAIL b2b_b got %h want %h", obs_b, {32'h80, 3'b010});
    end
    adv();
    jump_en = 1'b0;
    adv();
    #1;
    n_chk++;
    if (obs_b !== {32'h200, 3'b000}) begin
      n_fail++;
      $display("FAIL reload_b got %h want %h", obs_b, {32'h200, 3'b000});
    end
    n_chk++;
    if (obs_a !== {32'h200, 3'b100}) begin
      n_fail++;
      $display("FAIL reload_a got %h want %h", obs_a, {32'h200, 3'b100});
    end
    adv();
    #1;
    n_chk++;
    if (obs_b !== {32'h200, 3'b100}) begin
      n_fail++;
      $display("FAIL b2b_run_b got %h want %h", obs_b, {32'h200, 3'b100});
    end
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h208, 3'b100}) begin
      n_fail++;
      $display("FAIL b2b_inc_a got %h want %h", obs_a, {32'h208, 3'b100});
    end
  endtask

  task automatic test_jump_in_hold();
    hold = 1'b1;
    adv();
    jump_en = 1'b1;
    jump_addr = 32'h300;
    #1;
    n_chk++;
    if (obs_a !== {32'h208, 3'b110}) begin
      n_fail++;
      $display("FAIL hold_jmp got %h want %h", obs_a, {32'h208, 3'b110});
    end
    adv();
    jump_en = 1'b0;
    hold = 1'b0;
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h300, 3'b100}) begin
      n_fail++;
      $display("FAIL hold_tgt got %h want %h", obs_a, {32'h300, 3'b100});
    end
  endtask

  task automatic test_wrap();
    jump_en = 1'b1;
    jump_addr = 32'hFFFF_FFFC;
    adv();
    jump_en = 1'b0;
    adv();
    adv();
    #1;
    n_chk++;
    if (obs_a !== {32'h0, 3'b100}) begin
      n_fail++;
      $display("FAIL wrap got %h want %h", obs_a, {32'h0, 3'b100});
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic [32:0] exp_tr;
`ifdef PC_CTRL_MISALIGN_CHK_EN
    exp_pc = 32'h100;
    exp_tr = {1'b1, 32'h42};
`else
    exp_pc = 32'h40;
    exp_tr = 33'h0;
`endif
    jump_en = 1'b1;
    jump_addr = 32'h42;
    adv();
    jump_en = 1'b0;
    #1;
    n_chk++;
    if (bus_a.pc_o !== exp_pc) begin
      n_fail++;
      $display("FAIL mis_pc got %h want %h", bus_a.pc_o, exp_pc);
    end
    n_chk++;
    if ({bus_a.trap_o, bus_a.bad_addr_o} !== exp_tr) begin
      n_fail++;
      $display("FAIL mis_trap got %h want %h",
               {bus_a.trap_o, bus_a.bad_addr_o}, exp_tr);
    end
    adv();
    #1;
    n_chk++;
    if (bus_a.trap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_pulse got %b want 0", bus_a.trap_o);
    end
    jump_en = 1'b1;
    jump_addr = 32'h41;
    adv();
    jump_en = 1'b0;
    #1;
    n_chk++;
    if ({bus_a.pc_o, bus_a.trap_o} !== {32'h40, 1'b0}) begin
      n_fail++;
      $display("FAIL bit0 got %h want %h",
               {bus_a.pc_o, bus_a.trap_o}, {32'h40, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    jump_en = 1'b1;
    jump_addr = 32'h600;
    adv();
    jump_en = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bus_b.flush_o, bus_b.stall_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_ctl got %b want 00",
               {bus_b.flush_o, bus_b.stall_o});
    end
    adv();
    rst = 1'b0;
    #1;
    n_chk++;
    if (obs_b !== {32'h1000, 3'b000}) begin
      n_fail++;
      $display("FAIL mid_rst_b got %h want %h", obs_b, {32'h1000, 3'b000});
    end
    n_chk++;
    if ({obs_a, bus_a.trap_o} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL mid_rst_a got %h want 0", {obs_a, bus_a.trap_o});
    end
    adv();
    #1;
    n_chk++;
    if (obs_b !== {32'h1000, 3'b100}) begin
      n_fail++;
      $display("FAIL mid_boot_b got %h want %h", obs_b, {32'h1000, 3'b100});
    end
    adv();
    #1;
    n_chk++;
    if (obs_b !== {32'h1004, 3'b100}) begin
      n_fail++;
      $display("FAIL mid_inc_b got %h want %h", obs_b, {32'h1004, 3'b100});
    end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_hold();
    test_jump_hold();
    test_back_to_back();
    test_jump_in_hold();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
